// File: rtl/fpga_status_led_ctrl.sv
// fpga_status_led_ctrl: board status LEDs for the FPGA top wrapper.
// NUM_CH channels each select off / on / heartbeat / exit-code blink.
// The exit code is latched once from the SoC exit status. It is then
// blinked out as N one-slot pulses followed by a four-slot gap, and the
// pattern repeats until reset.
// Optional build macro STATUS_LED_RST_SYNC_EN: when defined, rst_ni is
// synchronised internally. It asserts asynchronously and deasserts after
// two clk_i edges.
module fpga_status_led_ctrl #(
    parameter int TICK_DIV_WIDTH = 27,
    parameter int NUM_CH         = 4,
    parameter int CODE_WIDTH     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [2*NUM_CH-1:0]     mode_i,
    input  logic                    exit_valid_i,
    input  logic [31:0]             exit_value_i,
    output logic [NUM_CH-1:0]       led_o,
    output logic                    exit_latched_o,
    output logic [CODE_WIDTH-1:0]   exit_code_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    logic                      rst_n;
    logic [TICK_DIV_WIDTH-1:0] cnt;
    logic                      heartbeat;
    logic                      slot_tick;
    state_t                    state;
    logic [CODE_WIDTH-1:0]     pulse_cnt;
    logic [1:0]                gap_cnt;
    logic                      exit_led;

`ifdef STATUS_LED_RST_SYNC_EN
    logic [1:0] rst_sync;

    // Reset synchroniser: assert immediately, release after two clean edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];
`else
    assign rst_n = rst_ni;
`endif

    // Free-running divider; heartbeat and slot timing both come from it
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + TICK_DIV_WIDTH'(1);
    end

    assign heartbeat = cnt[TICK_DIV_WIDTH-1];
    assign slot_tick = &cnt[TICK_DIV_WIDTH-3:0];

    // Upper exit_value_i bits and cnt[MSB-1] are intentionally not used
    logic unused_ok;
    assign unused_ok = ^{exit_value_i[31:CODE_WIDTH], cnt[TICK_DIV_WIDTH-2]};

    // Capture the first exit status; sticky until reset
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            exit_latched_o <= 1'b0;
            exit_code_o    <= '0;
        end else if (exit_valid_i && !exit_latched_o) begin
            exit_latched_o <= 1'b1;
            exit_code_o    <= exit_value_i[CODE_WIDTH-1:0];
        end
    end

    // Exit blink sequencer; advances only on slot boundaries
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
            exit_led  <= 1'b0;
        end else if (slot_tick) begin
            case (state)
                S_IDLE: begin
                    if (exit_latched_o) begin
                        if (exit_code_o == '0) begin
                            state    <= S_PASS;
                            exit_led <= 1'b1;
                        end else begin
                            state     <= S_ON;
                            pulse_cnt <= CODE_WIDTH'(1);
                            exit_led  <= 1'b1;
                        end
                    end
                end
                S_PASS: begin
                    exit_led <= 1'b1;
                end
                S_ON: begin
                    state    <= S_OFF;
                    exit_led <= 1'b0;
                end
                S_OFF: begin
                    if (pulse_cnt == exit_code_o) begin
                        state   <= S_GAP;
                        gap_cnt <= 2'd0;
                    end else begin
                        state     <= S_ON;
                        pulse_cnt <= pulse_cnt + CODE_WIDTH'(1);
                        exit_led  <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 2'd3) begin
                        state     <= S_ON;
                        pulse_cnt <= CODE_WIDTH'(1);
                        exit_led  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    exit_led <= 1'b0;
                end
            endcase
        end
    end

    // One registered mode mux per LED; all exit-mode channels share exit_led
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        fpga_status_led_ch u_ch (
            .clk_i     (clk_i),
            .rst_n     (rst_n),
            .mode      (mode_i[2*k +: 2]),
            .heartbeat (heartbeat),
            .exit_led  (exit_led),
            .led       (led_o[k])
        );
    end

endmodule

// Per-channel registered LED source select
module fpga_status_led_ch (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       heartbeat,
    input  logic       exit_led,
    output logic       led
);

    // Register the selected source so the board pin sees a clean flop output
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            led <= 1'b0;
        end else begin
            case (mode)
                2'b00:   led <= 1'b0;
                2'b01:   led <= 1'b1;
                2'b10:   led <= heartbeat;
                default: led <= exit_led;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Directed bench for fpga_status_led_ctrl at TICK_DIV_WIDTH=6
// (slot = 16 cycles, heartbeat period = 64 cycles).
module tb_fpga_status_led_ctrl;

    localparam int W   = 6;
    localparam int NCH = 4;
    localparam int CW  = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [7:0]    mode_i = 8'h00;
    logic          exit_valid_i = 1'b0;
    logic [31:0]   exit_value_i = 32'h0;
    logic [3:0]    led_o;
    logic          exit_latched_o;
    logic [3:0]    exit_code_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;   // rising edges since the design left reset

    always #5 clk_i = ~clk_i;

    fpga_status_led_ctrl #(
        .TICK_DIV_WIDTH (W),
        .NUM_CH         (NCH),
        .CODE_WIDTH     (CW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .mode_i         (mode_i),
        .exit_valid_i   (exit_valid_i),
        .exit_value_i   (exit_value_i),
        .led_o          (led_o),
        .exit_latched_o (exit_latched_o),
        .exit_code_o    (exit_code_o)
    );

    typedef struct {
        logic [7:0] mode;
        logic [3:0] exp_hb0;   // expected led_o while heartbeat is low
        logic [3:0] exp_hb1;   // expected led_o while heartbeat is high
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // After edge k the LED shows the counter value from before that edge (k-1)
    function automatic logic hb_exp(input int k);
        return ((k - 1) % 64) >= 32;
    endfunction

    // Exit LED after edge k, given the sequencer left IDLE on edge t with code c:
    // c pulses of one slot on / one slot off, then 4 slots dark, repeating.
    function automatic logic ex_exp(input int k, input int t, input int c);
        int d, s, p;
        if (k <= t) return 1'b0;
        if (c == 0) return 1'b1;
        d = k - t - 1;
        s = d / 16;
        p = s % (2 * c + 4);
        return (p < 2 * c) && (p % 2 == 0);
    endfunction

    // First slot_tick edge strictly after latch edge l
    function automatic int first_tick_after(input int l);
        return ((l / 16) + 1) * 16;
    endfunction

    task automatic do_reset();
        rst_ni       = 1'b0;
        exit_valid_i = 1'b0;
        exit_value_i = 32'h0;
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        chk("rst_led", 32'(led_o), 32'h0);
        chk("rst_latched", 32'(exit_latched_o), 32'h0);
        chk("rst_code", 32'(exit_code_o), 32'h0);
        rst_ni = 1'b1;
`ifdef STATUS_LED_RST_SYNC_EN
        repeat (2) begin
            @(posedge clk_i);
            #1;
            chk("sync_hold_led", 32'(led_o), 32'h0);
        end
`endif
        cyc = 0;
    endtask

    // Latch a code, then follow the blink pattern until edge t+1+span
    task automatic run_exit(input logic [31:0] value, input int code, input int span,
                            input string tag, output int t);
        int l;
        exit_valid_i = 1'b1;
        exit_value_i = value;
        l = cyc + 1;
        step();
        chk({tag, "_latched"}, 32'(exit_latched_o), 32'h1);
        chk({tag, "_code"}, 32'(exit_code_o), 32'(code));
        t = first_tick_after(l);
        while (cyc < t + 1 + span) begin
            step();
            chk({tag, "_led"}, 32'(led_o),
                32'({ex_exp(cyc, t, code), hb_exp(cyc), 1'b1, 1'b0}));
        end
    endtask

    initial begin
        int t;

        vecs[0] = '{mode: 8'hE4, exp_hb0: 4'b0010, exp_hb1: 4'b0110};
        vecs[1] = '{mode: 8'h00, exp_hb0: 4'b0000, exp_hb1: 4'b0000};
        vecs[2] = '{mode: 8'h55, exp_hb0: 4'b1111, exp_hb1: 4'b1111};
        vecs[3] = '{mode: 8'hAA, exp_hb0: 4'b0000, exp_hb1: 4'b1111};
        vecs[4] = '{mode: 8'hFF, exp_hb0: 4'b0000, exp_hb1: 4'b0000};
        vecs[5] = '{mode: 8'h1B, exp_hb0: 4'b0100, exp_hb1: 4'b0110};

        // 1: all heartbeat, first rise on edge 33 after release
        mode_i = 8'hAA;
        do_reset();
        for (int k = 1; k <= 140; k++) begin
            step();
            chk("hb_all", 32'(led_o), hb_exp(cyc) ? 32'hF : 32'h0);
        end

        // Table: mode combinations, no exit latched
        foreach (vecs[i]) begin
            mode_i = vecs[i].mode;
            repeat (40) begin
                step();
                chk("mode_vec", 32'(led_o),
                    32'(hb_exp(cyc) ? vecs[i].exp_hb1 : vecs[i].exp_hb0));
            end
        end

        // 2: mixed modes held for 1000 cycles
        mode_i = 8'hE4;
        repeat (1000) begin
            step();
            chk("mixed_led", 32'(led_o), 32'({1'b0, hb_exp(cyc), 1'b1, 1'b0}));
            chk("mixed_latched", 32'(exit_latched_o), 32'h0);
        end

        // 3: code 3, three full periods of 160 cycles
        do_reset();
        run_exit(32'h0000_0003, 3, 480, "code3", t);

        // 4: code 0 is steady on; later value changes are ignored
        do_reset();
        run_exit(32'h0000_0010, 0, 40, "code0", t);
        exit_value_i = 32'h5;
        repeat (20) begin
            step();
            chk("code0_hold_code", 32'(exit_code_o), 32'h0);
            chk("code0_hold_latched", 32'(exit_latched_o), 32'h1);
            chk("code0_hold_led3", 32'(led_o[3]), 32'h1);
        end

        // 5: code 15, reset asynchronously in the middle of pulse 7
        do_reset();
        run_exit(32'h0000_000F, 15, 200, "code15", t);
        chk("code15_mid_p7", 32'(led_o[3]), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_led", 32'(led_o), 32'h0);
        chk("async_rst_latched", 32'(exit_latched_o), 32'h0);
        chk("async_rst_code", 32'(exit_code_o), 32'h0);
        do_reset();
        repeat (60) begin
            step();
            chk("post_rst_latched", 32'(exit_latched_o), 32'h0);
            chk("post_rst_led", 32'(led_o), 32'({1'b0, hb_exp(cyc), 1'b1, 1'b0}));
        end
        run_exit(32'h0000_0002, 2, 256, "code2", t);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
